// File: rtl/nn_pkg.sv
// rtl/nn_pkg.sv - shared widths, post-accumulator state encoding and sign-magnitude helpers
package nn_pkg;

   localparam int SM_IN_W  = 21;
   localparam int SM_ACT_W = 8;
   localparam int ACT_MAX  = 127;

   typedef enum logic [1:0] {
      S_ACC  = 2'd0,
      S_NORM = 2'd1,
      S_OUT  = 2'd2
   } npa_state_t;

   // Negative zero maps to 0, so both MAC zero encodings accumulate identically.
   function automatic logic signed [31:0] sm_to_tc(input logic [31:0] sm, input int w);
      logic [31:0] mag;
      mag = sm & ((32'd1 << (w - 1)) - 32'd1);
      return sm[w-1] ? -$signed(mag) : $signed(mag);
   endfunction

   function automatic logic [31:0] tc_to_sm(input logic signed [31:0] v, input int w);
      logic [31:0] mag;
      logic [31:0] r;
      mag = (v < 0) ? 32'(-v) : 32'(v);
      r   = mag & ((32'd1 << (w - 1)) - 32'd1);
      if (v < 0 && r != 32'd0)
         r[w-1] = 1'b1;
      return r;
   endfunction

endpackage

// File: rtl/sm_saturate.sv
// rtl/sm_saturate.sv - accumulator to sign-magnitude activation: shift, clip, ReLU, zero-sign fix
module sm_saturate
   import nn_pkg::*;
#(
   parameter int ACC_W = 28,
   parameter int SHIFT = 6,
   parameter int OUT_W = SM_ACT_W
) (
   input  logic signed [ACC_W-1:0] acc,
   input  logic                    relu,
   output logic [OUT_W-1:0]        data,
   output logic                    sat
);

   localparam logic [ACC_W-1:0] MAXV = ACC_W'((1 << (OUT_W - 1)) - 1);

   logic             neg;
   logic [ACC_W-1:0] abs_v;
   logic [ACC_W-1:0] mag_full;
   logic [OUT_W-2:0] mag;

   // Shifting the magnitude, not the signed value, truncates toward zero.
   always_comb begin
      neg      = acc[ACC_W-1];
      abs_v    = neg ? ACC_W'(-acc) : ACC_W'(acc);
      mag_full = abs_v >> SHIFT;
      sat      = mag_full > MAXV;
      mag      = sat ? MAXV[OUT_W-2:0] : mag_full[OUT_W-2:0];
      if (neg && relu)
         data = '0;
      else if (mag == '0)
         data = '0;
      else
         data = {neg, mag};
   end

endmodule

// File: rtl/neuron_post_acc.sv
// rtl/neuron_post_acc.sv - accumulates MAC partial sums per neuron and emits an 8-bit activation
module neuron_post_acc
   import nn_pkg::*;
#(
   parameter int IN_W       = SM_IN_W,
   parameter int OUT_W      = SM_ACT_W,
   parameter int NUM_CHUNKS = 2,
   parameter int SHIFT      = 6,
   parameter int ACC_W      = 28
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_data,
   input  logic [OUT_W-1:0] bias,
   input  logic             relu_en,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data,
   output logic             out_sat,
   output logic             busy
);

   localparam int CNT_W = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_CHUNKS - 1);

   npa_state_t              state, state_nxt;
   logic [CNT_W-1:0]        chunk_cnt;
   logic signed [ACC_W-1:0] acc;
   logic signed [ACC_W-1:0] conv_in;
   logic signed [ACC_W-1:0] conv_bias;
   logic signed [31:0]      in_tc;
   logic signed [31:0]      bias_tc;
   logic signed [31:0]      bias_sh;
   logic                    relu_q;
   logic [OUT_W-1:0]        sat_data;
   logic                    sat_flag;
   logic                    last_chunk;

   assign in_tc      = sm_to_tc(32'(in_data), IN_W);
   assign bias_tc    = sm_to_tc(32'(bias), OUT_W);
   assign bias_sh    = bias_tc <<< SHIFT;
   assign conv_in    = in_tc[ACC_W-1:0];
   assign conv_bias  = bias_sh[ACC_W-1:0];
   assign last_chunk = (chunk_cnt == LAST);

   sm_saturate #(
      .ACC_W (ACC_W),
      .SHIFT (SHIFT),
      .OUT_W (OUT_W)
   ) u_sat (
      .acc  (acc),
      .relu (relu_q),
      .data (sat_data),
      .sat  (sat_flag)
   );

   always_ff @(posedge clk) begin
      if (!rst_n)
         state <= S_ACC;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_ACC:   if (in_valid && last_chunk) state_nxt = S_NORM;
         S_NORM:  state_nxt = S_OUT;
         S_OUT:   if (out_ready) state_nxt = S_ACC;
         default: state_nxt = S_ACC;
      endcase
   end

   always_comb begin
      in_ready  = (state == S_ACC);
      out_valid = (state == S_OUT);
      busy      = (chunk_cnt != '0) || (state != S_ACC);
   end

   // First chunk loads rather than adds, so bias and ReLU mode belong to this neuron only.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc       <= '0;
         chunk_cnt <= '0;
         relu_q    <= 1'b0;
         out_data  <= '0;
         out_sat   <= 1'b0;
      end else begin
         case (state)
            S_ACC: begin
               if (in_valid) begin
                  if (chunk_cnt == '0) begin
                     acc    <= conv_in + conv_bias;
                     relu_q <= relu_en;
                  end else begin
                     acc <= acc + conv_in;
                  end
                  chunk_cnt <= last_chunk ? '0 : chunk_cnt + 1'b1;
               end
            end
            S_NORM: begin
               out_data <= sat_data;
               out_sat  <= sat_flag;
            end
            S_OUT: begin
               if (out_ready)
                  acc <= '0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_neuron_post_acc.sv
// tb/tb_neuron_post_acc.sv - self-checking bench for neuron_post_acc
module tb_neuron_post_acc;

   logic        clk = 0;
   logic        rst_n = 0;
   logic        in_valid = 0;
   logic        in_ready;
   logic [20:0] in_data = '0;
   logic [7:0]  bias = '0;
   logic        relu_en = 0;
   logic        out_valid;
   logic        out_ready = 0;
   logic [7:0]  out_data;
   logic        out_sat;
   logic        busy;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   neuron_post_acc dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .bias      (bias),
      .relu_en   (relu_en),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_sat   (out_sat),
      .busy      (busy)
   );

   typedef struct {
      logic [20:0] c0;
      logic [20:0] c1;
      logic [7:0]  b;
      logic        r;
      logic [7:0]  exp_data;
      logic        exp_sat;
   } vec_t;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic int smv(input logic [31:0] v, input int w);
      int m;
      m = int'(v & ((32'd1 << (w - 1)) - 32'd1));
      return v[w-1] ? -m : m;
   endfunction

   // Reference: exact integer sum, divide the magnitude, then apply the output rules.
   function automatic logic [8:0] model(input logic [20:0] c0, input logic [20:0] c1,
                                        input logic [7:0] b, input logic r);
      int s, m;
      logic neg, sat;
      s   = smv(32'(c0), 21) + smv(32'(c1), 21) + smv(32'(b), 8) * 64;
      neg = s < 0;
      m   = (neg ? -s : s) / 64;
      sat = m > 127;
      if (sat) m = 127;
      if ((neg && r) || m == 0) return {sat, 8'h00};
      return {sat, neg, m[6:0]};
   endfunction

   task automatic send(input logic [20:0] d, input logic [7:0] b, input logic r);
      int t = 0;
      in_data = d; bias = b; relu_en = r; in_valid = 1;
      while (!in_ready && t < 100) begin @(posedge clk); #1; t++; end
      chk("in_ready_timeout", int'(in_ready), 1);
      @(posedge clk); #1;
      in_valid = 0;
   endtask

   task automatic get_result(input int hold, output logic [7:0] d, output logic s, output int lat);
      lat = 0;
      while (!out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
      chk("out_valid_timeout", int'(out_valid), 1);
      d = out_data; s = out_sat;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         chk("hold_stable", int'({out_valid, in_ready, out_sat, out_data}), int'({2'b10, s, d}));
      end
      out_ready = 1;
      @(posedge clk); #1;
      out_ready = 0;
      chk("release_valid", int'(out_valid), 0);
      chk("release_ready", int'(in_ready), 1);
   endtask

   function automatic logic [20:0] rnd_sm();
      logic [19:0] m;
      m = ($urandom_range(0, 3) == 0) ? 20'($urandom_range(0, 20'hFFFFF)) : 20'($urandom_range(0, 4000));
      return {1'($urandom_range(0, 1)), m};
   endfunction

   vec_t vecs[5];
   logic [7:0] d;
   logic s;
   int lat;
   logic [8:0] e;
   logic [20:0] r0, r1;
   logic [7:0] rb;
   logic rr;

   initial begin
      vecs[0] = '{21'h0003E8, 21'h1000C8, 8'h03, 1'b0, 8'h0F, 1'b0};
      vecs[1] = '{21'd20000,  21'd20000,  8'h00, 1'b0, 8'h7F, 1'b1};
      vecs[2] = '{21'h1003E8, 21'h000000, 8'h81, 1'b0, 8'h90, 1'b0};
      vecs[3] = '{21'h1003E8, 21'h000000, 8'h81, 1'b1, 8'h00, 1'b0};
      vecs[4] = '{21'h100000, 21'h100000, 8'h80, 1'b0, 8'h00, 1'b0};

      repeat (3) @(posedge clk);
      #1 rst_n = 1;
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_out_data", int'(out_data), 0);
      chk("rst_out_sat", int'(out_sat), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_in_ready", int'(in_ready), 1);

      for (int i = 0; i < 5; i++) begin
         send(vecs[i].c0, vecs[i].b, vecs[i].r);
         chk("busy_mid", int'(busy), 1);
         send(vecs[i].c1, 8'hFF, ~vecs[i].r);
         chk("norm_in_ready", int'(in_ready), 0);
         get_result(0, d, s, lat);
         chk($sformatf("vec%0d_data", i), int'(d), int'(vecs[i].exp_data));
         chk($sformatf("vec%0d_sat", i), int'(s), int'(vecs[i].exp_sat));
         chk($sformatf("vec%0d_latency", i), lat, 1);
      end

      // Backpressure: upstream offers the next neuron's first chunk while the result is held.
      send(21'd5000, 8'h05, 1'b0);
      send(21'h100100, 8'h00, 1'b0);
      get_result(0, d, s, lat);
      e = model(21'd5000, 21'h100100, 8'h05, 1'b0);
      chk("bp_first_data", int'(d), int'(e[7:0]));
      send(21'd7000, 8'h02, 1'b0);
      send(21'd300, 8'h00, 1'b0);
      lat = 0;
      while (!out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
      chk("bp_valid", int'(out_valid), 1);
      d = out_data; s = out_sat;
      in_data = 21'h100050; bias = 8'h84; relu_en = 1'b0; in_valid = 1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk("bp_stable", int'({out_valid, in_ready, out_sat, out_data}), int'({2'b10, s, d}));
      end
      e = model(21'd7000, 21'd300, 8'h02, 1'b0);
      chk("bp_data", int'(d), int'(e[7:0]));
      out_ready = 1;
      @(posedge clk); #1;
      out_ready = 0;
      chk("bp_release_valid", int'(out_valid), 0);
      chk("bp_release_ready", int'(in_ready), 1);
      send(21'h100050, 8'h84, 1'b0);
      send(21'd900, 8'h00, 1'b1);
      get_result(0, d, s, lat);
      e = model(21'h100050, 21'd900, 8'h84, 1'b0);
      chk("bp_next_data", int'(d), int'(e[7:0]));
      chk("bp_next_sat", int'(s), int'(e[8]));

      // Reset mid-neuron drops the first chunk.
      send(21'd1000, 8'h00, 1'b0);
      rst_n = 0;
      @(posedge clk); #1;
      rst_n = 1;
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_valid", int'(out_valid), 0);
      send(21'd64, 8'h00, 1'b0);
      send(21'd64, 8'h00, 1'b0);
      get_result(0, d, s, lat);
      chk("midrst_data", int'(d), 8'h02);
      chk("midrst_sat", int'(s), 0);

      for (int n = 0; n < 60; n++) begin
         r0 = rnd_sm(); r1 = rnd_sm();
         rb = 8'($urandom_range(0, 255)); rr = 1'($urandom_range(0, 1));
         send(r0, rb, rr);
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #0;
         send(r1, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
         get_result($urandom_range(0, 3), d, s, lat);
         e = model(r0, r1, rb, rr);
         chk($sformatf("rnd%0d_data", n), int'(d), int'(e[7:0]));
         chk($sformatf("rnd%0d_sat", n), int'(s), int'(e[8]));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
